// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight writers in a STAGES-deep scoreboard and
// produces forward selects, load-use stalls and redirect flushes for the decode stage.
module pipe_hazard_ctrl #(
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter bit          RF_BYPASS  = 1'b0,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_reg_write_i,
    input  logic             id_is_load_i,
    input  logic             id_redirect_i,
    input  logic             ex_redirect_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             flush_id_o,
    output logic             bubble_ex_o,
    output logic [SEL_W-1:0] fwd_rs1_sel_o,
    output logic [SEL_W-1:0] fwd_rs2_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } entry_t;

    entry_t           ent_q [1:STAGES];
    entry_t           ent_d [1:STAGES];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [SEL_W-1:0] sel1, sel2;
    logic             hz1, hz2;
    logic             load_use;

    function automatic logic hit(entry_t e, logic [4:0] rs, logic use_rs, logic vld);
        return e.valid && e.reg_write && (e.rd == rs) && (rs != 5'd0) && use_rs && vld;
    endfunction

    function automatic logic avail(entry_t e, int unsigned k);
        return !e.is_load || (k >= LOAD_STAGE);
    endfunction

    function automatic logic [SEL_W-1:0] sel_of(entry_t e, int unsigned k);
        if (!avail(e, k) || (k == STAGES && RF_BYPASS))
            return '0;
        return SEL_W'(k);
    endfunction

    // Walk oldest to youngest so the youngest matching stage is the last one written.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        hz1  = 1'b0;
        hz2  = 1'b0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (hit(ent_q[STAGES-i], id_rs1_i, id_use_rs1_i, id_valid_i)) begin
                hz1  = !avail(ent_q[STAGES-i], STAGES - i);
                sel1 = sel_of(ent_q[STAGES-i], STAGES - i);
            end
            if (hit(ent_q[STAGES-i], id_rs2_i, id_use_rs2_i, id_valid_i)) begin
                hz2  = !avail(ent_q[STAGES-i], STAGES - i);
                sel2 = sel_of(ent_q[STAGES-i], STAGES - i);
            end
        end
    end

    assign load_use = hz1 | hz2;

    always_comb begin
        stall_if_o    = 1'b0;
        stall_id_o    = 1'b0;
        flush_id_o    = 1'b0;
        bubble_ex_o   = 1'b0;
        fwd_rs1_sel_o = '0;
        fwd_rs2_sel_o = '0;
        ent_d         = ent_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (!rst_i) begin
            if (!start_i) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
            end else begin
                fwd_rs1_sel_o = sel1;
                fwd_rs2_sel_o = sel2;
                if (ex_redirect_i) begin
                    flush_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                end else if (load_use) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                end else if (id_redirect_i) begin
                    flush_id_o = 1'b1;
                end

                for (int unsigned k = 2; k <= STAGES; k++)
                    ent_d[k] = ent_q[k-1];
                ent_d[1] = bubble_ex_o ? '0
                         : {id_valid_i, id_rd_i, id_reg_write_i, id_is_load_i};

                if (stall_if_o && stall_cnt_q != '1)
                    stall_cnt_d = stall_cnt_q + 1'b1;
                if ((flush_id_o || bubble_ex_o) && flush_cnt_q != '1)
                    flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 1; k <= STAGES; k++)
                ent_q[k] <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: default instance plus an RF_BYPASS=1, CNT_W=2
// instance driven in lock-step to cover write-through forwarding and counter saturation.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, id_valid, use1, use2, rw, ld, idr, exr;
    logic [4:0] rs1, rs2, rd;

    logic        a_sif, a_sid, a_fl, a_bub;
    logic [1:0]  a_s1, a_s2;
    logic [31:0] a_scnt, a_fcnt;
    logic        b_sif, b_sid, b_fl, b_bub;
    logic [1:0]  b_s1, b_s2;
    logic [1:0]  b_scnt, b_fcnt;

    always #10 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .id_valid_i(id_valid),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
        .id_rd_i(rd), .id_reg_write_i(rw), .id_is_load_i(ld),
        .id_redirect_i(idr), .ex_redirect_i(exr),
        .stall_if_o(a_sif), .stall_id_o(a_sid), .flush_id_o(a_fl), .bubble_ex_o(a_bub),
        .fwd_rs1_sel_o(a_s1), .fwd_rs2_sel_o(a_s2),
        .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
    );

    pipe_hazard_ctrl #(.RF_BYPASS(1'b1), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .id_valid_i(id_valid),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
        .id_rd_i(rd), .id_reg_write_i(rw), .id_is_load_i(ld),
        .id_redirect_i(idr), .ex_redirect_i(exr),
        .stall_if_o(b_sif), .stall_id_o(b_sid), .flush_id_o(b_fl), .bubble_ex_o(b_bub),
        .fwd_rs1_sel_o(b_s1), .fwd_rs2_sel_o(b_s2),
        .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    typedef struct {
        bit st; bit v; logic [4:0] rs1; bit u1; logic [4:0] rs2; bit u2;
        logic [4:0] rd; bit rw; bit ld; bit idr; bit exr;
    } stim_t;

    typedef struct {
        string      name;
        logic [7:0] outs;   // {stall_if, stall_id, flush_id, bubble_ex, sel1, sel2}
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;

    function automatic stim_t ins(bit v, int r1, bit u1, int r2, bit u2, int d, bit w, bit l,
                                  bit ir = 1'b0, bit er = 1'b0, bit st = 1'b1);
        stim_t s;
        s.st = st; s.v = v; s.rs1 = 5'(r1); s.u1 = u1; s.rs2 = 5'(r2); s.u2 = u2;
        s.rd = 5'(d); s.rw = w; s.ld = l; s.idr = ir; s.exr = er;
        return s;
    endfunction

    function automatic logic [7:0] eo(bit sif, bit sid, bit fl, bit bub, int s1, int s2);
        return {sif, sid, fl, bub, 2'(s1), 2'(s2)};
    endfunction

    function automatic logic [7:0] obs_a();
        return {a_sif, a_sid, a_fl, a_bub, a_s1, a_s2};
    endfunction

    function automatic logic [7:0] obs_b();
        return {b_sif, b_sid, b_fl, b_bub, b_s1, b_s2};
    endfunction

    task automatic apply(input stim_t s);
        start = s.st; id_valid = s.v; rs1 = s.rs1; use1 = s.u1; rs2 = s.rs2; use2 = s.u2;
        rd = s.rd; rw = s.rw; ld = s.ld; idr = s.idr; exr = s.exr;
    endtask

    task automatic drive(input stim_t s, input string name, input logic [7:0] e);
        @(negedge clk);
        apply(s);
        sb.push_back('{name, e});
    endtask

    // Counter model advanced for the clock edge that follows a compared step.
    task automatic model_clock(input stim_t s, input logic [7:0] e);
        if (s.st) begin
            if (e[7]) exp_stall++;
            if (e[5] | e[4]) exp_flush++;
        end
    endtask

    task automatic drain();
        repeat (3) begin
            @(negedge clk);
            apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        apply(ins(1, 1, 1, 1, 1, 1, 1, 1, 1, 1));
        sb.push_back('{"reset_outs", eo(0, 0, 0, 0, 0, 0)});
        sb.push_back('{"reset_outs_b", eo(0, 0, 0, 0, 0, 0)});
        repeat (2) @(negedge clk);
        #1;
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.outs) begin
            failures++; $display("FAIL %s: got %b expected %b", e.name, obs_a(), e.outs);
        end
        e = sb.pop_front(); checks++;
        if (obs_b() !== e.outs) begin
            failures++; $display("FAIL %s: got %b expected %b", e.name, obs_b(), e.outs);
        end
        checks++;
        if (a_scnt !== 32'd0 || a_fcnt !== 32'd0) begin
            failures++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", a_scnt, a_fcnt);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
        #1; checks++;
        if (obs_a() !== eo(0, 0, 0, 0, 0, 0)) begin
            failures++; $display("FAIL reset_idle: got %b expected %b", obs_a(), eo(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_forward();
        stim_t s[3]; logic [7:0] x[3]; exp_t e;
        s[0] = ins(1, 2, 1, 3, 1, 1, 1, 0);  x[0] = eo(0, 0, 0, 0, 0, 0);
        s[1] = ins(1, 1, 1, 1, 1, 2, 1, 0);  x[1] = eo(0, 0, 0, 0, 1, 1);
        s[2] = ins(1, 1, 1, 2, 1, 9, 0, 0);  x[2] = eo(0, 0, 0, 0, 2, 1);
        for (int i = 0; i < 3; i++) begin
            drive(s[i], $sformatf("fwd%0d", i), x[i]);
            #1; e = sb.pop_front(); checks++;
            if (obs_a() !== e.outs) begin
                failures++; $display("FAIL %s: got %b expected %b", e.name, obs_a(), e.outs);
            end
            model_clock(s[i], e.outs);
        end
        drain();
    endtask

    task automatic test_load_use();
        stim_t s[3]; logic [7:0] x[3]; exp_t e;
        s[0] = ins(1, 6, 1, 0, 0, 5, 1, 1);  x[0] = eo(0, 0, 0, 0, 0, 0);
        s[1] = ins(1, 5, 1, 0, 1, 6, 1, 0);  x[1] = eo(1, 1, 0, 1, 0, 0);
        s[2] = s[1];                         x[2] = eo(0, 0, 0, 0, 2, 0);
        for (int i = 0; i < 3; i++) begin
            drive(s[i], $sformatf("lu%0d", i), x[i]);
            #1; e = sb.pop_front(); checks++;
            if (obs_a() !== e.outs) begin
                failures++; $display("FAIL %s: got %b expected %b", e.name, obs_a(), e.outs);
            end
            model_clock(s[i], e.outs);
        end
        checks++;
        if (a_scnt !== 32'(exp_stall - 0) || exp_stall != 1) begin
            failures++; $display("FAIL lu_stall_cnt: got %0d expected 1", a_scnt);
        end
        checks++;
        if (a_fcnt !== 32'(exp_flush)) begin
            failures++; $display("FAIL lu_flush_cnt: got %0d expected %0d", a_fcnt, exp_flush);
        end
        drain();
    endtask

    task automatic test_x0();
        stim_t s[4]; logic [7:0] x[4]; exp_t e;
        s[0] = ins(1, 0, 0, 0, 0, 0, 1, 0);   x[0] = eo(0, 0, 0, 0, 0, 0);
        s[1] = ins(1, 0, 1, 0, 1, 3, 1, 1);   x[1] = eo(0, 0, 0, 0, 0, 0);
        s[2] = ins(1, 0, 0, 0, 0, 3, 1, 0);   x[2] = eo(0, 0, 0, 0, 0, 0);
        s[3] = ins(1, 3, 1, 3, 1, 11, 1, 0);  x[3] = eo(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            drive(s[i], $sformatf("x0_%0d", i), x[i]);
            #1; e = sb.pop_front(); checks++;
            if (obs_a() !== e.outs) begin
                failures++; $display("FAIL %s: got %b expected %b", e.name, obs_a(), e.outs);
            end
            model_clock(s[i], e.outs);
        end
        drain();
    endtask

    task automatic test_rf_bypass();
        stim_t s[4]; logic [7:0] x[4]; exp_t e;
        s[0] = ins(1, 0, 0, 0, 0, 4, 1, 0);   x[0] = eo(0, 0, 0, 0, 0, 0);
        s[1] = ins(0, 0, 0, 0, 0, 0, 0, 0);   x[1] = eo(0, 0, 0, 0, 0, 0);
        s[2] = s[1];                          x[2] = eo(0, 0, 0, 0, 0, 0);
        s[3] = ins(1, 4, 1, 4, 1, 12, 0, 0);  x[3] = eo(0, 0, 0, 0, 3, 3);
        for (int i = 0; i < 4; i++) begin
            drive(s[i], $sformatf("wb%0d", i), x[i]);
            if (i == 3) sb.push_back('{"wb_bypass", eo(0, 0, 0, 0, 0, 0)});
            #1; e = sb.pop_front(); checks++;
            if (obs_a() !== e.outs) begin
                failures++; $display("FAIL %s: got %b expected %b", e.name, obs_a(), e.outs);
            end
            model_clock(s[i], e.outs);
        end
        e = sb.pop_front(); checks++;
        if (obs_b() !== e.outs) begin
            failures++; $display("FAIL %s: got %b expected %b", e.name, obs_b(), e.outs);
        end
        drain();
    endtask

    task automatic test_redirect();
        stim_t s[6]; logic [7:0] x[6]; exp_t e; int unsigned sat;
        s[0] = ins(1, 0, 0, 0, 0, 8, 1, 0, 1, 0);   x[0] = eo(0, 0, 1, 0, 0, 0);
        s[1] = ins(1, 0, 0, 0, 0, 7, 1, 1);         x[1] = eo(0, 0, 0, 0, 0, 0);
        s[2] = ins(1, 7, 1, 0, 0, 13, 1, 0, 1, 1);  x[2] = eo(0, 0, 1, 1, 0, 0);
        s[3] = ins(1, 0, 0, 0, 0, 9, 1, 1);         x[3] = eo(0, 0, 0, 0, 0, 0);
        s[4] = ins(1, 0, 0, 9, 1, 14, 1, 0, 1, 0);  x[4] = eo(1, 1, 0, 1, 0, 0);
        s[5] = s[4];                                x[5] = eo(0, 0, 1, 0, 0, 2);
        for (int i = 0; i < 6; i++) begin
            drive(s[i], $sformatf("redir%0d", i), x[i]);
            #1; e = sb.pop_front(); checks++;
            if (obs_a() !== e.outs) begin
                failures++; $display("FAIL %s: got %b expected %b", e.name, obs_a(), e.outs);
            end
            if (i == 3) begin
                checks++;
                if (a_scnt !== 32'(exp_stall) || a_fcnt !== 32'(exp_flush)) begin
                    failures++;
                    $display("FAIL redir_squash_cnt: got %0d/%0d expected %0d/%0d",
                             a_scnt, a_fcnt, exp_stall, exp_flush);
                end
            end
            model_clock(s[i], e.outs);
        end
        @(negedge clk);
        apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
        #1; checks++;
        if (a_scnt !== 32'(exp_stall) || a_fcnt !== 32'(exp_flush)) begin
            failures++;
            $display("FAIL redir_cnt: got %0d/%0d expected %0d/%0d", a_scnt, a_fcnt, exp_stall, exp_flush);
        end
        sat = (exp_flush > 3) ? 3 : exp_flush;
        checks++;
        if (b_fcnt !== 2'(sat)) begin
            failures++; $display("FAIL sat_flush_cnt: got %0d expected %0d", b_fcnt, sat);
        end
        sat = (exp_stall > 3) ? 3 : exp_stall;
        checks++;
        if (b_scnt !== 2'(sat)) begin
            failures++; $display("FAIL sat_stall_cnt: got %0d expected %0d", b_scnt, sat);
        end
        drain();
    endtask

    task automatic test_start_hold();
        stim_t s[5]; logic [7:0] x[5]; exp_t e;
        s[0] = ins(1, 0, 0, 0, 0, 10, 1, 1);                 x[0] = eo(0, 0, 0, 0, 0, 0);
        s[1] = ins(1, 10, 1, 0, 0, 15, 1, 0, 0, 0, 0);       x[1] = eo(1, 1, 0, 0, 0, 0);
        s[2] = s[1];                                         x[2] = x[1];
        s[3] = s[1];                                         x[3] = x[1];
        s[4] = ins(1, 10, 1, 0, 0, 15, 1, 0);                x[4] = eo(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(s[i], $sformatf("hold%0d", i), x[i]);
            #1; e = sb.pop_front(); checks++;
            if (obs_a() !== e.outs) begin
                failures++; $display("FAIL %s: got %b expected %b", e.name, obs_a(), e.outs);
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (a_scnt !== 32'(exp_stall) || a_fcnt !== 32'(exp_flush)) begin
                    failures++;
                    $display("FAIL hold_cnt%0d: got %0d/%0d expected %0d/%0d",
                             i, a_scnt, a_fcnt, exp_stall, exp_flush);
                end
            end
            if (i < 4) model_clock(s[i], e.outs);
        end
        #2 rst = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        sb.push_back('{"rst_mid_stall", eo(0, 0, 0, 0, 0, 0)});
        #1; e = sb.pop_front(); checks++;
        if (obs_a() !== e.outs) begin
            failures++; $display("FAIL %s: got %b expected %b", e.name, obs_a(), e.outs);
        end
        checks++;
        if (a_scnt !== 32'(exp_stall) || a_fcnt !== 32'(exp_flush)) begin
            failures++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", a_scnt, a_fcnt);
        end
        #2 rst = 1'b0;
        sb.push_back('{"rst_release", eo(0, 0, 0, 0, 0, 0)});
        #1; e = sb.pop_front(); checks++;
        if (obs_a() !== e.outs) begin
            failures++; $display("FAIL %s: got %b expected %b", e.name, obs_a(), e.outs);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_x0();
        test_rf_bypass();
        test_redirect();
        test_start_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
